conv_encoder_stream: RTL and testbench
======================================

Name: conv_encoder_stream

Overview:
- Parametrised, frame-based convolutional encoder; successor to the fixed-size encoder.
- K and code rate are runtime-selected up to compile-time maxima. Generator polynomials are loaded per frame.
- Input and output use valid/ready handshakes. A zero-tail flush of K-1 bits terminates the trellis.
- Sits between the bit source and the channel/modulator model. Its output stream is the stimulus for the Viterbi decoder path.

Parameters:
- MAX_K, 9, maximum constraint length; shift register is MAX_K-1 bits.
- MAX_CODE_RATE, 3, maximum output bits per input bit; rates 1/2 and 1/3 supported.
- FRAME_W, 16, width of the frame-length field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high. Only one clock in the block.
- i_cfg_load  in  1  capture configuration; honoured only in IDLE.
- i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3.
- i_constr_len  in  2  00 = K3, 01 = K5, 10 = K7, 11 = K9 (values above MAX_K clamp to MAX_K).
- i_gen_poly  in  MAX_CODE_RATE*MAX_K  polynomial j occupies bits [j*MAX_K +: MAX_K].
- i_frame_len  in  FRAME_W  number of information bits in the frame.
- i_in_valid  in  1  information bit valid.
- i_in_bit  in  1  information bit.
- o_in_ready  out  1  encoder accepts a bit this cycle.
- o_out_valid  out  1  codeword valid.
- i_out_ready  in  1  sink accepts the codeword.
- o_encoder_data  out  MAX_CODE_RATE  codeword; bit j = output of polynomial j.
- o_data_mask  out  MAX_CODE_RATE  which bits of o_encoder_data are meaningful.
- o_tail  out  1  current codeword belongs to the tail.
- o_busy  out  1  frame in progress.
- o_encoder_done  out  1  one-cycle pulse after the last tail codeword is accepted.

Behaviour:
- Reset: all outputs 0, shift register 0, counters 0, state IDLE. Captured configuration cleared to rate 1/2, K3, polys 0.
- States and transitions:
  - IDLE: i_cfg_load with i_frame_len != 0 latches all cfg inputs → RUN. i_cfg_load with i_frame_len == 0 is ignored.
  - RUN: when the bit count reaches frame_len → FLUSH.
  - FLUSH: when K-1 tail codewords have been accepted by the sink → DONE.
  - DONE: one cycle; o_encoder_done = 1 → IDLE.
- i_cfg_load outside IDLE is ignored; the configuration stays frozen for the whole frame.
- Encoding: register vector v = {in, sr[K-2:0]}, with sr[K-2] the newest past bit. Polynomial bit K-1 taps the input bit; bit 0 taps the oldest bit. Polynomial bits above K-1 are ignored.
- Codeword: o_encoder_data[j] = ^(poly_j[K-1:0] & v). The shift register updates to {in, sr[K-2:1]} on each accepted bit.
- Rate 1/2: bit 2 is forced to 0 and o_data_mask = 3'b011. Rate 1/3: o_data_mask = 3'b111.
- Output register: single stage.
  - Latency is one cycle from input handshake to o_out_valid.
  - o_in_ready = (state == RUN) && (!o_out_valid || i_out_ready), so full throughput of 1 bit/cycle is possible.
  - While o_out_valid && !i_out_ready, o_encoder_data, o_data_mask and o_tail hold stable.
- FLUSH: the encoder generates zero input internally and does not use i_in_valid (o_in_ready = 0). A tail codeword is launched whenever the output register is free or being drained. o_tail = 1 on those codewords.
- o_busy = 1 in RUN and FLUSH.
- Both counters are FRAME_W bits and never wrap. The bit counter saturates at frame_len.
- rst asserted mid-frame aborts immediately to the reset state. No done pulse is produced and the pending codeword is dropped.

Optional Feature:
- Macro: CONV_ENC_PUNCT_EN.
- With the macro: adds input i_punct_en, latched at cfg load. When set at rate 1/2, the rate becomes 2/3 with puncture pattern [11;10].
  - Odd-numbered codewords (second, fourth, ...) carry o_data_mask = 3'b001 and have bit 1 forced to 0.
  - The pattern counter restarts at each frame and continues through the tail.
  - i_punct_en is ignored at rate 1/3.
- Without the macro: no port; o_data_mask is fixed per rate.

Decomposition:
- Shared package / param_def.v: MAX_K, MAX_CODE_RATE, constr_len decode constants (K3/K5/K7/K9), FSM state encodings, rate codes.
- Sub-module conv_enc_core: combinational tap-and-XOR of v against the MAX_CODE_RATE polynomials with K masking. The top level holds the FSM, counters, shift register and output register.

Test Plan:
- K3, polys 7/5 octal, rate 1/2, frame_len 4, input 1,0,1,1, i_out_ready=1:
  - information codewords (bit0,bit1) = 11,10,00,01;
  - tail codewords 01,11 with o_tail=1;
  - o_encoder_done pulses exactly once.
- K7, polys 171/133/165 octal, rate 1/3, frame 1 (input bit 1) + tail: the 7 codewords equal the poly bits MSB-first, i.e. an impulse response; o_data_mask = 111.
- Repeat the first case with i_out_ready toggled 1,0,0,1,...:
  - identical codeword sequence;
  - o_encoder_data stable during stalls;
  - no bit accepted while stalled and full.
- Assert rst for 1 cycle after the 2nd input bit: all outputs are 0 next cycle, state is IDLE, and there is no done pulse. A new frame then encodes from a zero state.
- i_cfg_load with a different poly during RUN: ignored, and codewords match the original config. i_cfg_load with frame_len 0 in IDLE: o_busy stays 0.
- CONV_ENC_PUNCT_EN, first-case setup with i_punct_en=1: o_data_mask sequence 011,001,011,001,011,001 and bit1 = 0 on masked words.

Source files
------------

// File: rtl/conv_encoder_stream_pkg.sv
// conv_encoder_stream_pkg: shared sizes, constraint-length codes, rate codes and FSM states
// for the frame-based convolutional encoder.
package conv_encoder_stream_pkg;
    localparam int DEF_MAX_K         = 9;
    localparam int DEF_MAX_CODE_RATE = 3;
    localparam int DEF_FRAME_W       = 16;
    localparam int K_W               = 5;

    localparam logic [1:0] CL_K3 = 2'b00;
    localparam logic [1:0] CL_K5 = 2'b01;
    localparam logic [1:0] CL_K7 = 2'b10;
    localparam logic [1:0] CL_K9 = 2'b11;

    localparam logic RATE_1_2 = 1'b0;
    localparam logic RATE_1_3 = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    function automatic logic [K_W-1:0] decode_k(input logic [1:0] cl, input int max_k);
        logic [K_W-1:0] k;
        k = cl == CL_K3 ? K_W'(3) : cl == CL_K5 ? K_W'(5) : cl == CL_K7 ? K_W'(7) : K_W'(9);
        return k > K_W'(max_k) ? K_W'(max_k) : k;
    endfunction
endpackage

// File: rtl/conv_encoder_stream_core.sv
// conv_enc_core: tap-and-XOR of the register vector against every generator polynomial,
// with polynomial bits at or above the active constraint length masked off.
module conv_enc_core
    import conv_encoder_stream_pkg::*;
#(
    parameter int MAX_K         = DEF_MAX_K,
    parameter int MAX_CODE_RATE = DEF_MAX_CODE_RATE
) (
    input  logic [MAX_K-1:0]               v,
    input  logic [K_W-1:0]                 k,
    input  logic [MAX_CODE_RATE*MAX_K-1:0] poly,
    output logic [MAX_CODE_RATE-1:0]       code
);
    logic [MAX_K-1:0] k_mask;

    assign k_mask = {MAX_K{1'b1}} >> (K_W'(MAX_K) - k);

    for (genvar j = 0; j < MAX_CODE_RATE; j++) begin : g_poly
        assign code[j] = ^(poly[j*MAX_K +: MAX_K] & k_mask & v);
    end
endmodule

// File: rtl/conv_encoder_stream.sv
// conv_encoder_stream: frame-based convolutional encoder with valid/ready streaming and zero-tail flush.
// Optional rate-2/3 puncturing is enabled by defining CONV_ENC_PUNCT_EN.
module conv_encoder_stream
    import conv_encoder_stream_pkg::*;
#(
    parameter int MAX_K         = DEF_MAX_K,
    parameter int MAX_CODE_RATE = DEF_MAX_CODE_RATE,
    parameter int FRAME_W       = DEF_FRAME_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_cfg_load,
    input  logic                           i_code_rate,
    input  logic [1:0]                     i_constr_len,
    input  logic [MAX_CODE_RATE*MAX_K-1:0] i_gen_poly,
    input  logic [FRAME_W-1:0]             i_frame_len,
`ifdef CONV_ENC_PUNCT_EN
    input  logic                           i_punct_en,
`endif
    input  logic                           i_in_valid,
    input  logic                           i_in_bit,
    output logic                           o_in_ready,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [MAX_CODE_RATE-1:0]       o_encoder_data,
    output logic [MAX_CODE_RATE-1:0]       o_data_mask,
    output logic                           o_tail,
    output logic                           o_busy,
    output logic                           o_encoder_done
);
    localparam int SRW = MAX_K - 1;

    state_t                         state;
    logic                           cfg_rate;
    logic [K_W-1:0]                 cfg_k;
    logic [MAX_CODE_RATE*MAX_K-1:0] cfg_poly;
    logic [FRAME_W-1:0]             cfg_len, bit_cnt, tail_cnt;
    logic [SRW-1:0]                 sr, sr_next;
    logic [MAX_K-1:0]               v;
    logic [MAX_CODE_RATE-1:0]       code, rate_mask, word_mask;
    logic                           start, in_acc, drain, tail_go, load, in_b, pun;

    assign start     = state == IDLE && i_cfg_load && i_frame_len != '0;
    assign drain     = !o_out_valid || i_out_ready;
    assign o_in_ready = state == RUN && drain;
    assign in_acc    = i_in_valid && o_in_ready;
    assign tail_go   = state == FLUSH && drain && tail_cnt != FRAME_W'(cfg_k) - FRAME_W'(1);
    assign load      = in_acc || tail_go;
    // Tail codewords shift in zeros, so the input bit only matters while running.
    assign in_b      = state == RUN && i_in_bit;
    assign v         = (MAX_K'(in_b) << (cfg_k - K_W'(1))) | MAX_K'(sr);
    assign sr_next   = (sr >> 1) | (SRW'(in_b) << (cfg_k - K_W'(2)));
    assign rate_mask = cfg_rate == RATE_1_3 ? '1 : MAX_CODE_RATE'(3);
    assign word_mask = pun ? MAX_CODE_RATE'(1) : rate_mask;
    assign o_busy    = state == RUN || state == FLUSH;

    conv_enc_core #(.MAX_K(MAX_K), .MAX_CODE_RATE(MAX_CODE_RATE)) u_core (
        .v    (v),
        .k    (cfg_k),
        .poly (cfg_poly),
        .code (code)
    );

`ifdef CONV_ENC_PUNCT_EN
    logic cfg_punct, pat;
    assign pun = cfg_punct && cfg_rate == RATE_1_2 && pat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_punct <= 1'b0;
            pat       <= 1'b0;
        end else if (start) begin
            cfg_punct <= i_punct_en;
            pat       <= 1'b0;
        end else if (load) begin
            pat <= ~pat;
        end
    end
`else
    assign pun = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cfg_rate       <= RATE_1_2;
            cfg_k          <= K_W'(3);
            cfg_poly       <= '0;
            cfg_len        <= '0;
            bit_cnt        <= '0;
            tail_cnt       <= '0;
            sr             <= '0;
            o_out_valid    <= 1'b0;
            o_encoder_data <= '0;
            o_data_mask    <= '0;
            o_tail         <= 1'b0;
            o_encoder_done <= 1'b0;
        end else begin
            o_encoder_done <= 1'b0;
            o_out_valid    <= load || (o_out_valid && !i_out_ready);
            if (load) begin
                o_encoder_data <= code & word_mask;
                o_data_mask    <= word_mask;
                o_tail         <= state == FLUSH;
                sr             <= sr_next;
            end
            case (state)
                IDLE: if (start) begin
                    cfg_rate <= i_code_rate;
                    cfg_k    <= decode_k(i_constr_len, MAX_K);
                    cfg_poly <= i_gen_poly;
                    cfg_len  <= i_frame_len;
                    bit_cnt  <= '0;
                    tail_cnt <= '0;
                    sr       <= '0;
                    state    <= RUN;
                end
                RUN: if (in_acc) begin
                    bit_cnt <= bit_cnt + FRAME_W'(1);
                    if (bit_cnt + FRAME_W'(1) == cfg_len) state <= FLUSH;
                end
                FLUSH: begin
                    if (tail_go) tail_cnt <= tail_cnt + FRAME_W'(1);
                    // All tails launched, so the register now holds the last one.
                    if (!tail_go && tail_cnt == FRAME_W'(cfg_k) - FRAME_W'(1) && o_out_valid && i_out_ready) begin
                        state          <= DONE;
                        o_encoder_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_encoder_stream.sv
// tb_conv_encoder_stream: randomized self-checking bench; expected codewords come from a
// direct convolution of the frame bits (plus K-1 zeros) with each generator polynomial.
module tb_conv_encoder_stream;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_cfg_load = 1'b0, i_code_rate = 1'b0;
    logic [1:0]  i_constr_len = 2'b00;
    logic [26:0] i_gen_poly = '0;
    logic [15:0] i_frame_len = '0;
    logic        i_in_valid = 1'b0, i_in_bit = 1'b0, i_out_ready = 1'b1;
    logic        o_in_ready, o_out_valid, o_tail, o_busy, o_encoder_done;
    logic [2:0]  o_encoder_data, o_data_mask;
`ifdef CONV_ENC_PUNCT_EN
    logic        i_punct_en = 1'b0;
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif

    int vectors = 0, miscompares = 0;
    int n_done, n_stall_err;
    logic [2:0] obs_data[$], obs_mask[$], exp_data[$], exp_mask[$];
    logic       obs_tail[$], exp_tail[$];

    conv_encoder_stream dut (
        .clk(clk), .rst(rst), .i_cfg_load(i_cfg_load), .i_code_rate(i_code_rate),
        .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_frame_len(i_frame_len),
`ifdef CONV_ENC_PUNCT_EN
        .i_punct_en(i_punct_en),
`endif
        .i_in_valid(i_in_valid), .i_in_bit(i_in_bit), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_encoder_data(o_encoder_data),
        .o_data_mask(o_data_mask), .o_tail(o_tail), .o_busy(o_busy), .o_encoder_done(o_encoder_done)
    );

    always #5 clk = ~clk;

    function automatic void build_expected(input logic rate, input int k, input logic [26:0] poly,
                                           input bit bits[$], input bit punct);
        int len = bits.size();
        exp_data.delete(); exp_mask.delete(); exp_tail.delete();
        for (int n = 0; n < len + k - 1; n++) begin
            logic [2:0] d = '0, m;
            for (int j = 0; j < 3; j++)
                for (int t = 0; t < k; t++)
                    if (n - t >= 0 && n - t < len) d[j] = d[j] ^ (poly[j*9 + k-1-t] & bits[n-t]);
            m = rate ? 3'b111 : (punct && n % 2 == 1) ? 3'b001 : 3'b011;
            exp_data.push_back(d & m);
            exp_mask.push_back(m);
            exp_tail.push_back(n >= len);
        end
    endfunction

    // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready and random input gaps.
    task automatic run_frame(input logic rate, input logic [1:0] cl, input logic [26:0] poly,
                             input bit bits[$], input int mode, input bit punct, input bit glitch);
        int idx = 0, cyc = 0, extra = 0;
        logic hold = 1'b0, pt = 1'b0;
        logic [2:0] pd = '0, pm = '0;
        obs_data.delete(); obs_mask.delete(); obs_tail.delete();
        n_done = 0; n_stall_err = 0;
        i_code_rate = rate; i_constr_len = cl; i_gen_poly = poly; i_frame_len = 16'(bits.size());
`ifdef CONV_ENC_PUNCT_EN
        i_punct_en = punct;
`endif
        i_cfg_load = 1'b1;
        @(posedge clk); #1;
        i_cfg_load = 1'b0;
        while (extra < 4 && cyc < 2000) begin
            i_out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            i_in_valid = idx < bits.size() && (mode != 2 || $urandom_range(0, 3) != 0);
            i_in_bit = i_in_valid ? bits[idx] : 1'b0;
            if (glitch) begin
                i_cfg_load = cyc == 2;
                i_gen_poly = ~poly;
                i_frame_len = 16'd3;
            end
            #1;
            if (hold && (!o_out_valid || o_encoder_data !== pd || o_data_mask !== pm || o_tail !== pt))
                n_stall_err++;
            if (o_out_valid && !i_out_ready && o_in_ready) n_stall_err++;
            if (o_out_valid && i_out_ready) begin
                obs_data.push_back(o_encoder_data);
                obs_mask.push_back(o_data_mask);
                obs_tail.push_back(o_tail);
            end
            if (i_in_valid && o_in_ready) idx++;
            hold = o_out_valid && !i_out_ready;
            pd = o_encoder_data; pm = o_data_mask; pt = o_tail;
            @(posedge clk); #1;
            if (o_encoder_done) n_done++;
            if (n_done > 0) extra++;
            cyc++;
        end
        i_in_valid = 1'b0; i_out_ready = 1'b1; i_cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({o_out_valid, o_encoder_data, o_data_mask, o_tail, o_busy, o_encoder_done, o_in_ready} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_held outputs got %b want 0",
                     {o_out_valid, o_encoder_data, o_data_mask, o_tail, o_busy, o_encoder_done, o_in_ready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({o_out_valid, o_busy, o_encoder_done, o_in_ready} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_released outputs got %b want 0", {o_out_valid, o_busy, o_encoder_done, o_in_ready});
        end
    endtask

    task automatic test_k3_basic(input int mode, input string name);
        logic [2:0] ed[6] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b011};
        logic       et[6] = '{0, 0, 0, 0, 1, 1};
        run_frame(1'b0, 2'b00, {9'o0, 9'o5, 9'o7}, '{1, 0, 1, 1}, mode, 1'b0, 1'b0);
        vectors++;
        if (obs_data.size() != 6) begin
            miscompares++;
            $display("FAIL %s count got %0d want 6", name, obs_data.size());
        end
        for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
            vectors++;
            if ({obs_data[i], obs_mask[i], obs_tail[i]} !== {ed[i], 3'b011, et[i]}) begin
                miscompares++;
                $display("FAIL %s word%0d got d=%b m=%b t=%b want d=%b m=011 t=%b",
                         name, i, obs_data[i], obs_mask[i], obs_tail[i], ed[i], et[i]);
            end
        end
        vectors++;
        if (n_done != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses got %0d want 1", name, n_done);
        end
        vectors++;
        if (n_stall_err != 0) begin
            miscompares++;
            $display("FAIL %s stall_stability got %0d violations want 0", name, n_stall_err);
        end
    endtask

    task automatic test_k7_impulse();
        logic [26:0] p = {9'o165, 9'o133, 9'o171};
        run_frame(1'b1, 2'b10, p, '{1}, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_data.size() != 7) begin
            miscompares++;
            $display("FAIL k7_count got %0d want 7", obs_data.size());
        end
        for (int n = 0; n < 7 && n < obs_data.size(); n++) begin
            logic [2:0] e = {p[18 + 6 - n], p[9 + 6 - n], p[6 - n]};
            vectors++;
            if ({obs_data[n], obs_mask[n], obs_tail[n]} !== {e, 3'b111, n >= 1}) begin
                miscompares++;
                $display("FAIL k7_word%0d got d=%b m=%b t=%b want d=%b m=111 t=%b",
                         n, obs_data[n], obs_mask[n], obs_tail[n], e, n >= 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int dones = 0;
        i_code_rate = 1'b0; i_constr_len = 2'b00; i_gen_poly = {9'o0, 9'o5, 9'o7}; i_frame_len = 16'd4;
        i_out_ready = 1'b1; i_cfg_load = 1'b1;
        @(posedge clk); #1;
        i_cfg_load = 1'b0; i_in_valid = 1'b1; i_in_bit = 1'b1;
        @(posedge clk); #1;
        i_in_bit = 1'b0;
        @(posedge clk); #1;
        i_in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({o_out_valid, o_encoder_data, o_data_mask, o_tail, o_busy, o_encoder_done, o_in_ready} !== 11'd0) begin
            miscompares++;
            $display("FAIL midframe_reset outputs got %b want 0",
                     {o_out_valid, o_encoder_data, o_data_mask, o_tail, o_busy, o_encoder_done, o_in_ready});
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (o_encoder_done) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL midframe_no_done got %0d pulses want 0", dones);
        end
        run_frame(1'b0, 2'b00, {9'o0, 9'o5, 9'o7}, '{1, 0, 1, 1}, 0, 1'b0, 1'b0);
        build_expected(1'b0, 3, {9'o0, 9'o5, 9'o7}, '{1, 0, 1, 1}, 1'b0);
        vectors++;
        if (obs_data != exp_data || obs_mask != exp_mask || obs_tail != exp_tail) begin
            miscompares++;
            $display("FAIL post_reset_frame got %0d words (first d=%b) want %0d words (first d=%b)",
                     obs_data.size(), obs_data.size() ? obs_data[0] : 3'bx, exp_data.size(), exp_data[0]);
        end
    endtask

    task automatic test_cfg_ignore();
        bit bits[$];
        logic [26:0] p = {9'o0, 9'o23, 9'o35};
        for (int i = 0; i < 8; i++) bits.push_back(1'($urandom_range(0, 1)));
        run_frame(1'b0, 2'b01, p, bits, 0, 1'b0, 1'b1);
        build_expected(1'b0, 5, p, bits, 1'b0);
        vectors++;
        if (obs_data != exp_data || obs_tail != exp_tail || n_done != 1) begin
            miscompares++;
            $display("FAIL cfg_glitch got %0d words done=%0d want %0d words done=1",
                     obs_data.size(), n_done, exp_data.size());
        end
        i_frame_len = 16'd0; i_cfg_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_cfg_load = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_load busy got %b ready %b want 0 0", o_busy, o_in_ready);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            bit bits[$];
            logic rate = 1'($urandom_range(0, 1));
            logic [1:0] cl = 2'($urandom_range(0, 3));
            logic [26:0] p = 27'($urandom);
            bit pn = PUNCT && $urandom_range(0, 1) == 1;
            int len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(0, 1)));
            run_frame(rate, cl, p, bits, 2, pn, 1'b0);
            build_expected(rate, 2 * cl + 3, p, bits, pn);
            vectors++;
            if (obs_data.size() != exp_data.size()) begin
                miscompares++;
                $display("FAIL rand%0d count got %0d want %0d", f, obs_data.size(), exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                vectors++;
                if ({obs_data[i], obs_mask[i], obs_tail[i]} !== {exp_data[i], exp_mask[i], exp_tail[i]}) begin
                    miscompares++;
                    $display("FAIL rand%0d word%0d got d=%b m=%b t=%b want d=%b m=%b t=%b", f, i,
                             obs_data[i], obs_mask[i], obs_tail[i], exp_data[i], exp_mask[i], exp_tail[i]);
                end
            end
            vectors++;
            if (n_done != 1 || n_stall_err != 0) begin
                miscompares++;
                $display("FAIL rand%0d handshake done=%0d stall_err=%0d want 1 0", f, n_done, n_stall_err);
            end
        end
    endtask

`ifdef CONV_ENC_PUNCT_EN
    task automatic test_punct();
        logic [2:0] em[6] = '{3'b011, 3'b001, 3'b011, 3'b001, 3'b011, 3'b001};
        run_frame(1'b0, 2'b00, {9'o0, 9'o5, 9'o7}, '{1, 0, 1, 1}, 0, 1'b1, 1'b0);
        build_expected(1'b0, 3, {9'o0, 9'o5, 9'o7}, '{1, 0, 1, 1}, 1'b1);
        vectors++;
        if (obs_data.size() != 6) begin
            miscompares++;
            $display("FAIL punct_count got %0d want 6", obs_data.size());
        end
        for (int i = 0; i < 6 && i < obs_data.size(); i++) begin
            vectors++;
            if (obs_mask[i] !== em[i] || obs_data[i] !== exp_data[i]) begin
                miscompares++;
                $display("FAIL punct_word%0d got d=%b m=%b want d=%b m=%b",
                         i, obs_data[i], obs_mask[i], exp_data[i], em[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_k3_basic(0, "k3_basic");
        test_k7_impulse();
        test_k3_basic(1, "k3_stall");
        test_reset_midframe();
        test_cfg_ignore();
        test_random();
`ifdef CONV_ENC_PUNCT_EN
        test_punct();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
